// File: rtl/regbank_pkg.sv
// Shared constants and state encoding for the register-bank write arbiter.
package regbank_pkg;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned NREGS = 32;

  typedef enum logic {
    StRun,
    StSweep
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  int unsigned    idx;
  logic [PW-1:0]  sel;
  logic           found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = PW'(idx);
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter for the shared bank write port, with a zero-fill sweep of all registers.
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter bit          ZERO_PROTECT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               init_start,
  output logic               init_busy,
  output logic               init_done,
  output logic               bank_write,
  output logic [AW-1:0]      bank_dr,
  output logic [DW-1:0]      bank_wdata
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // One extra bit so the counter can mark the trailing cycle after address NREGS-1.
  localparam int unsigned CW = $clog2(NREGS) + 1;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   dr_q, dr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            done_q, done_d;
  logic [NREQ-1:0] grant;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    wr_d      = 1'b0;
    dr_d      = dr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    req_ready = '0;
    unique case (state_q)
      StRun: begin
        // Gate with reset so no grant is visible while the block is held in reset.
        req_ready = grant & {NREQ{reset}};
        for (int i = 0; i < int'(NREQ); i++) begin
          if (req_ready[i] && req_valid[i]) begin
            ptr_d   = (i == int'(NREQ) - 1) ? '0 : PW'(i + 1);
            dr_d    = req_addr[i*AW +: AW];
            wdata_d = req_data[i*DW +: DW];
            wr_d    = !(ZERO_PROTECT && (req_addr[i*AW +: AW] == '0));
          end
        end
        if (init_start) begin
          state_d = StSweep;
          cnt_d   = '0;
        end
      end
      StSweep: begin
        if (cnt_q == CW'(NREGS)) begin
          state_d = StRun;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          wr_d    = 1'b1;
          dr_d    = cnt_q[AW-1:0];
          wdata_d = '0;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      dr_q    <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      dr_q    <= dr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign init_busy  = (state_q == StSweep);
  assign init_done  = done_q;
  assign bank_write = wr_q;
  assign bank_dr    = dr_q;
  assign bank_wdata = wdata_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Randomized scoreboard bench for regbank_write_arbiter (NREQ=4, ZERO_PROTECT=1).
module tb_regbank_write_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   req_valid;
  logic [19:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         init_start;
  logic         init_busy;
  logic         init_done;
  logic         bank_write;
  logic [4:0]   bank_dr;
  logic [31:0]  bank_wdata;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state
  int ptr_m     = 0;
  int busy_left = 0;
  bit done_flag = 1'b0;

  typedef struct {
    int          cyc;
    logic [4:0]  dr;
    logic [31:0] d;
  } wr_t;
  wr_t sb[$];

  regbank_write_arbiter #(
    .NREQ         (4),
    .ZERO_PROTECT (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .init_start (init_start),
    .init_busy  (init_busy),
    .init_done  (init_done),
    .bank_write (bank_write),
    .bank_dr    (bank_dr),
    .bank_wdata (bank_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic [19:0] a, input logic [127:0] d,
                      input logic init);
    int         k;
    logic [3:0] er;
    logic [4:0] ad;
    bit         eb;
    @(posedge clk);
    #1;
    req_valid  = v;
    req_addr   = a;
    req_data   = d;
    init_start = init;
    #3;
    eb = (busy_left > 0);
    er = '0;
    k  = -1;
    if (!eb) begin
      for (int off = 0; off < N; off++) begin
        if (k < 0 && v[(ptr_m + off) % N]) k = (ptr_m + off) % N;
      end
    end
    if (k >= 0) er[k] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("init_busy", 64'(init_busy), 64'(eb));
    chk("init_done", 64'(init_done), 64'(done_flag));
    done_flag = 1'b0;
    if (eb) begin
      busy_left--;
      if (busy_left == 0) done_flag = 1'b1;
    end else begin
      if (k >= 0) begin
        ad = a[5*k +: 5];
        if (ad != 5'd0) sb.push_back('{cyc + 1, ad, d[32*k +: 32]});
        ptr_m = (k + 1) % N;
      end
      if (init) begin
        busy_left = 33;
        for (int r = 0; r < 32; r++) sb.push_back('{cyc + 2 + r, 5'(r), 32'h0});
      end
    end
  endtask

  task automatic rstep(input logic [3:0] v, input logic init, input bit allow_zero);
    logic [19:0]  a;
    logic [127:0] d;
    for (int i = 0; i < N; i++) begin
      if (allow_zero && $urandom_range(0, 7) == 0) a[5*i +: 5] = 5'd0;
      else a[5*i +: 5] = 5'($urandom_range(1, 31));
      d[32*i +: 32] = $urandom;
    end
    step(v, a, d, init);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'h0);
    chk({tag, "_bank_write"}, 64'(bank_write), 64'h0);
    chk({tag, "_bank_dr"}, 64'(bank_dr), 64'h0);
    chk({tag, "_bank_wdata"}, 64'(bank_wdata), 64'h0);
    chk({tag, "_init_busy"}, 64'(init_busy), 64'h0);
    chk({tag, "_init_done"}, 64'(init_done), 64'h0);
  endtask

  // Asynchronous reset partway through a cycle; pending model work is discarded.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    sb.delete();
    ptr_m      = 0;
    busy_left  = 0;
    done_flag  = 1'b0;
    req_valid  = '0;
    init_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: every bank write must match the head of the scoreboard, in the expected cycle.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bank_write) begin
          if (sb.size() == 0) begin
            chk("unexpected_write", 64'(bank_write), 64'h0);
          end else begin
            e = sb.pop_front();
            chk("wr_cycle", 64'(cyc), 64'(e.cyc));
            chk("bank_dr", 64'(bank_dr), 64'(e.dr));
            chk("bank_wdata", 64'(bank_wdata), 64'(e.d));
          end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          chk("missed_write", 64'(bank_write), 64'h1);
        end
      end
    end
  end

  initial begin
    logic [19:0]  a;
    logic [127:0] d;
    req_valid  = 4'hF;
    req_addr   = 20'hFFFFF;
    req_data   = '1;
    init_start = 1'b0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    req_valid = '0;
    reset     = 1'b1;

    // All requesters valid from reset: grants 0,1,2,3,0
    repeat (5) rstep(4'hF, 1'b0, 1'b0);

    // Single requester 2 writing addr 7
    a = '0;
    d = '0;
    a[10 +: 5] = 5'd7;
    d[64 +: 32] = 32'hDEADBEEF;
    step(4'b0100, a, d, 1'b0);

    // Requester 1 writes addr 0 (suppressed), then requester 2 takes the next grant
    a = 20'hFFFFF;
    a[5 +: 5] = 5'd0;
    d = {4{32'h1234_5678}};
    step(4'b0010, a, d, 1'b0);
    rstep(4'b0110, 1'b0, 1'b0);

    // Full sweep with everybody requesting
    rstep(4'hF, 1'b1, 1'b0);
    repeat (36) rstep(4'hF, 1'b0, 1'b0);

    // Sweep with a second init_start in sweep cycle 5
    rstep(4'hF, 1'b1, 1'b0);
    repeat (4) rstep(4'hF, 1'b0, 1'b0);
    rstep(4'hF, 1'b1, 1'b0);
    repeat (32) rstep(4'hF, 1'b0, 1'b0);

    // Reset in sweep cycle 10
    rstep(4'hF, 1'b1, 1'b0);
    repeat (9) rstep(4'hF, 1'b0, 1'b0);
    mid_reset();
    repeat (4) rstep(4'hF, 1'b0, 1'b0);

    // Random traffic with occasional sweeps
    repeat (400) rstep(4'($urandom), ($urandom_range(0, 63) == 0), 1'b1);

    repeat (40) rstep(4'h0, 1'b0, 1'b0);
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
